apb_fsm_controller: RTL and testbench

- APB-side sequencer of the AHB2APB bridge; sits between the AHB slave interface and the APB peripherals.
- Consumes the slave interface's decoded `valid` and `tempselx` together with the raw AHB address, write flag and write data.
- Runs the APB setup/access protocol and drives `Hreadyout` back to AHB to insert wait states.
- Supports single read and write transfers, including back-to-back transfers with no idle cycle between them.

---
 rtl/apb_fsm_controller.sv | 140 ++++++++++++++
 tb/tb_apb_fsm_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB2APB bridge. Turns decoded AHB transfers
// into APB setup/access cycles and throttles AHB through Hreadyout.
// Every output is a flop; the *_d values are the ones loaded on the edge
// that leaves the current state.
module apb_fsm_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NSEL       = 3
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  valid,
    input  logic                  Hwrite,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic [NSEL-1:0]       tempselx,
    output logic                  Hreadyout,
    output logic [NSEL-1:0]       Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic [DATA_WIDTH-1:0] Pwdata
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WWAIT   = 3'd1,
        ST_RSETUP  = 3'd2,
        ST_RACCESS = 3'd3,
        ST_WSETUP  = 3'd4,
        ST_WACCESS = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  hreadyout_q, hreadyout_d;
    logic [NSEL-1:0]       pselx_q, pselx_d;
    logic [NSEL-1:0]       sel_q, sel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

    // State and registered outputs; reset abandons any transfer in flight
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            pselx_q     <= '0;
            sel_q       <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            pselx_q     <= pselx_d;
            sel_q       <= sel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    // Next state; idle and both access states take a new transfer directly
    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE, ST_RACCESS, ST_WACCESS: begin
                if (valid) state_d = Hwrite ? ST_WWAIT : ST_RSETUP;
                else       state_d = ST_IDLE;
            end
            ST_WWAIT:  state_d = ST_WSETUP;
            ST_RSETUP: state_d = ST_RACCESS;
            ST_WSETUP: state_d = ST_WACCESS;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output values loaded on the edge leaving the current state.
    // Writes park the select in sel_q for one cycle because Hwdata only
    // becomes valid in the data phase.
    always_comb begin
        hreadyout_d = hreadyout_q;
        pselx_d     = pselx_q;
        sel_d       = sel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        unique case (state_q)
            ST_IDLE, ST_RACCESS, ST_WACCESS: begin
                penable_d = 1'b0;
                if (valid && !Hwrite) begin
                    paddr_d     = Haddr;
                    pselx_d     = tempselx;
                    pwrite_d    = 1'b0;
                    hreadyout_d = 1'b0;
                end else if (valid) begin
                    paddr_d     = Haddr;
                    sel_d       = tempselx;
                    pselx_d     = '0;
                    hreadyout_d = 1'b0;
                end else begin
                    pselx_d     = '0;
                    pwrite_d    = 1'b0;
                    hreadyout_d = 1'b1;
                end
            end
            ST_WWAIT: begin
                pwdata_d = Hwdata;
                pselx_d  = sel_q;
                pwrite_d = 1'b1;
            end
            ST_RSETUP, ST_WSETUP: begin
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end
            default: begin
                // Unreachable encodings fall back to the reset picture
                hreadyout_d = 1'b1;
                pselx_d     = '0;
                sel_d       = '0;
                penable_d   = 1'b0;
                pwrite_d    = 1'b0;
                paddr_d     = '0;
                pwdata_d    = '0;
            end
        endcase
    end

    assign Hreadyout = hreadyout_q;
    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: a vector table walks reads,
// writes and back-to-back transfers; hand sequences cover async reset,
// long idle and reset in the middle of a write.
module tb_apb_fsm_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int OW = 1 + NS + 1 + 1 + AW + DW;

    logic          Hclk = 1'b0;
    logic          Hresetn;
    logic          valid;
    logic          Hwrite;
    logic [AW-1:0] Haddr;
    logic [DW-1:0] Hwdata;
    logic [NS-1:0] tempselx;
    logic          Hreadyout;
    logic [NS-1:0] Pselx;
    logic          Penable;
    logic          Pwrite;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata;

    int checks = 0;
    int errors = 0;

    apb_fsm_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NSEL(NS)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite),
        .Haddr(Haddr), .Hwdata(Hwdata), .tempselx(tempselx),
        .Hreadyout(Hreadyout), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata)
    );

    always #5 Hclk = ~Hclk;

    typedef struct packed {
        logic          valid;
        logic          hwrite;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hwdata;
        logic [NS-1:0] sel;
        logic          e_hready;
        logic [NS-1:0] e_pselx;
        logic          e_penable;
        logic          e_pwrite;
        logic [AW-1:0] e_paddr;
        logic [DW-1:0] e_pwdata;
    } vec_t;

    // Observed outputs as {Hreadyout, Pselx, Penable, Pwrite, Paddr, Pwdata}
    function automatic logic [OW-1:0] outs();
        return {Hreadyout, Pselx, Penable, Pwrite, Paddr, Pwdata};
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got hrdy=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h, want hrdy=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h",
                     name, act[OW-1], act[OW-2 -: NS], act[AW+DW+1], act[AW+DW], act[AW+DW-1 -: AW], act[DW-1:0],
                     exp[OW-1], exp[OW-2 -: NS], exp[AW+DW+1], exp[AW+DW], exp[AW+DW-1 -: AW], exp[DW-1:0]);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NS-1:0] s);
        valid = v; Hwrite = w; Haddr = a; Hwdata = d; tempselx = s;
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    vec_t vec [12];

    initial begin
        // read, write, write->read and read->write back-to-back, then idle
        vec[0]  = '{1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 32'h8000_0010, 32'h0};
        vec[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 3'b001, 1'b1, 1'b0, 32'h8000_0010, 32'h0};
        vec[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 32'h8000_0010, 32'h0};
        vec[3]  = '{1'b1, 1'b1, 32'h8400_0020, 32'h0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 32'h8400_0020, 32'h0};
        vec[4]  = '{1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 3'b000, 1'b0, 3'b010, 1'b0, 1'b1, 32'h8400_0020, 32'hDEAD_BEEF};
        vec[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 32'h8400_0020, 32'hDEAD_BEEF};
        vec[6]  = '{1'b1, 1'b0, 32'h8800_0000, 32'h0, 3'b100, 1'b0, 3'b100, 1'b0, 1'b0, 32'h8800_0000, 32'hDEAD_BEEF};
        vec[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 3'b100, 1'b1, 1'b0, 32'h8800_0000, 32'hDEAD_BEEF};
        vec[8]  = '{1'b1, 1'b1, 32'h8000_0004, 32'h0, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF};
        vec[9]  = '{1'b0, 1'b0, 32'h0, 32'h1234_5678, 3'b000, 1'b0, 3'b001, 1'b0, 1'b1, 32'h8000_0004, 32'h1234_5678};
        vec[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 3'b001, 1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678};
        vec[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 32'h8000_0004, 32'h1234_5678};

        Hresetn = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);

        // Async reset asserted before any clock edge
        #3 Hresetn = 1'b0;
        #1 chk("reset_async", outs(), {1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0});
        step();
        step();
        Hresetn = 1'b1;
        step();
        chk("reset_release_idle", outs(), {1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0});

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].valid, vec[i].hwrite, vec[i].haddr, vec[i].hwdata, vec[i].sel);
            step();
            chk($sformatf("vec%0d", i), outs(),
                {vec[i].e_hready, vec[i].e_pselx, vec[i].e_penable, vec[i].e_pwrite,
                 vec[i].e_paddr, vec[i].e_pwdata});
        end

        // Ten idle cycles: nothing moves
        drive(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle%0d", i), outs(), {1'b1, 3'b000, 1'b0, 1'b0, 32'h8000_0004, 32'h1234_5678});
        end

        // Reset while in WSETUP
        drive(1'b1, 1'b1, 32'h8C00_0040, '0, 3'b100);
        step();
        drive(1'b0, 1'b0, '0, 32'hA5A5_0F0F, '0);
        step();
        chk("wsetup_before_reset", outs(), {1'b0, 3'b100, 1'b0, 1'b1, 32'h8C00_0040, 32'hA5A5_0F0F});
        #3 Hresetn = 1'b0;
        #1 chk("reset_in_wsetup", outs(), {1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0});
        step();
        Hresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_reset%0d", i), outs(), {1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0});
        end

        // New read after the abandoned write
        drive(1'b1, 1'b0, 32'h8000_0100, '0, 3'b010);
        step();
        chk("recover_rsetup", outs(), {1'b0, 3'b010, 1'b0, 1'b0, 32'h8000_0100, 32'h0});
        drive(1'b0, 1'b0, '0, '0, '0);
        step();
        chk("recover_raccess", outs(), {1'b1, 3'b010, 1'b1, 1'b0, 32'h8000_0100, 32'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
